audio_i2s_tx: RTL

//  I2S transmitter clocked by the 12.288 MHz audio PLL output (MCLK). Accepts stereo
//  PCM samples from the theremin synthesis chain via a valid/ready handshake.

---
 rtl/audio_pkg.sv | 13 +
 rtl/i2s_timing_gen.sv | 67 ++++++
 rtl/audio_i2s_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared defaults and FSM encoding for the I2S transmitter.
package audio_pkg;

  localparam int DATA_W_DEF         = 16;
  localparam int MCLK_PER_BCLK_DEF  = 4;
  localparam int BCLK_PER_FRAME_DEF = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/i2s_timing_gen.sv
// BCLK/LRCLK generation from MCLK plus the per-frame load strobe.
module i2s_timing_gen
  import audio_pkg::*;
#(
  parameter int MCLK_PER_BCLK  = MCLK_PER_BCLK_DEF,
  parameter int BCLK_PER_FRAME = BCLK_PER_FRAME_DEF,
  localparam int DIV_W = (MCLK_PER_BCLK > 1) ? $clog2(MCLK_PER_BCLK) : 1,
  localparam int BIT_W = $clog2(BCLK_PER_FRAME)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             active,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             bclk,
  output logic             lrclk,
  output logic             load_stb
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             cnt_en, div_max, bit_max, fall_stb;

  // Counters only advance once RUN has been held for a full cycle, so the
  // entry cycle leaves them at 0 and the first BCLK rise lands half a period + 1 later.
  always_comb begin
    cnt_en    = run && active;
    div_max   = (div_cnt_q == DIV_W'(MCLK_PER_BCLK - 1));
    bit_max   = (bit_cnt_q == BIT_W'(BCLK_PER_FRAME - 1));
    fall_stb  = cnt_en && div_max;
    load_stb  = fall_stb && bit_max;

    div_cnt_d = '0;
    bit_cnt_d = '0;
    if (cnt_en) begin
      div_cnt_d = div_max ? '0 : div_cnt_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      if (fall_stb) begin
        bit_cnt_d = bit_max ? '0 : bit_cnt_q + 1'b1;
      end
    end

    bclk_d  = run && (div_cnt_q >= DIV_W'(MCLK_PER_BCLK / 2));
    lrclk_d = run && (bit_cnt_q >= BIT_W'(BCLK_PER_FRAME / 2));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign bit_cnt = bit_cnt_q;
  assign bclk    = bclk_q;
  assign lrclk   = lrclk_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: lock synchroniser, RUN/IDLE FSM, one-deep sample
// hold with valid/ready input, and slot serialiser.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int MCLK_PER_BCLK  = MCLK_PER_BCLK_DEF,
  parameter int BCLK_PER_FRAME = BCLK_PER_FRAME_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              underrun
);

  localparam int BIT_W = $clog2(BCLK_PER_FRAME);
  localparam int HALF  = BCLK_PER_FRAME / 2;

  logic                sync1_q, lock_s_q;
  state_e              state_q, state_d;
  logic                run, active;
  logic [BIT_W-1:0]    bit_cnt;
  logic                load_stb;

  logic [DATA_W-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic                s_ready_q, s_ready_d;
  logic                sdata_q, sdata_d;
  logic                underrun_q, underrun_d;
  logic                xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lock_s_q)  state_d = RUN;
      RUN:     if (!lock_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by the next state so they clear on the same edge the FSM leaves RUN.
  assign run    = (state_d == RUN);
  assign active = (state_q == RUN);

  i2s_timing_gen #(
    .MCLK_PER_BCLK  (MCLK_PER_BCLK),
    .BCLK_PER_FRAME (BCLK_PER_FRAME)
  ) u_timing (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .active   (active),
    .bit_cnt  (bit_cnt),
    .bclk     (i2s_bclk),
    .lrclk    (i2s_lrclk),
    .load_stb (load_stb)
  );

  // Handshake: a pair transfers on any clk edge where s_valid and s_ready are
  // both high; s_ready is high only in RUN while the hold register is empty.
  always_comb begin
    xfer        = s_valid && s_ready_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    underrun_d  = 1'b0;

    if (!run) begin
      hold_l_d    = '0;
      hold_r_d    = '0;
      hold_full_d = 1'b0;
      shift_l_d   = '0;
      shift_r_d   = '0;
    end else begin
      if (load_stb) begin
        if (hold_full_q) begin
          shift_l_d   = hold_l_q;
          shift_r_d   = hold_r_q;
          hold_full_d = 1'b0;
        end else begin
          underrun_d  = 1'b1;
        end
      end
      if (xfer) begin
        hold_l_d    = s_left;
        hold_r_d    = s_right;
        hold_full_d = 1'b1;
      end
    end

    s_ready_d = run && !hold_full_d;

    // Slot k carries bit DATA_W-k, giving the one-BCLK delay after each LRCLK edge.
    sdata_d = 1'b0;
    if (run) begin
      for (int k = 1; k <= DATA_W; k++) begin
        if (bit_cnt == BIT_W'(k))        sdata_d = shift_l_q[DATA_W-k];
        if (bit_cnt == BIT_W'(HALF + k)) sdata_d = shift_r_q[DATA_W-k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      shift_l_q   <= '0;
      shift_r_q   <= '0;
      s_ready_q   <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      s_ready_q   <= s_ready_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;

endmodule
